// File: rtl/seq_shift_add_mul_if.sv
// Start/busy/done handshake and operand/result bus for the sequential multiplier.
interface seq_shift_add_mul_if #(
    parameter int unsigned N = 32
);
    logic             start;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    // Requester side (execute stage).
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_shift_add_mul.sv
// Multi-cycle unsigned N x N -> 2N shift-add multiplier built around one
// shared ripple-carry adder; one partial product is accumulated per cycle.

// Plain n-bit ripple-carry adder; the carry out of the top bit is not needed
// by callers that zero-extend their operands by one bit.
module rca_adder #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  logic         i_cin,
    output logic [n-1:0] o_sum
);
    logic [n-1:0] w_carry;

    assign w_carry[0] = i_cin;

    // Sum bit for every position.
    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_sum
            assign o_sum[gi] = i_a[gi] ^ i_b[gi] ^ w_carry[gi];
        end
        // Carry chain into every bit above the first.
        for (gi = 0; gi < n - 1; gi++) begin : g_carry
            assign w_carry[gi+1] = (i_a[gi] & i_b[gi]) |
                                   (i_a[gi] & w_carry[gi]) |
                                   (i_b[gi] & w_carry[gi]);
        end
    endgenerate
endmodule

module seq_shift_add_mul #(
    parameter int unsigned N = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_shift_add_mul_if.slave    bus
);
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned PW = 2 * N;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     r_state;
    logic [N-1:0]   r_mcand;
    logic [PW-1:0]  r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic [PW-1:0]  r_product;

    logic [1:0]     w_state_nxt;
    logic [N-1:0]   w_mcand_nxt;
    logic [PW-1:0]  w_acc_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;
    logic [PW-1:0]  w_product_nxt;

    logic [N:0]     w_add_a;
    logic [N:0]     w_add_b;
    logic [N:0]     w_sum;
    logic [PW-1:0]  w_acc_step;

    // Partial-product operands: running sum plus multiplicand gated by the
    // next multiplier bit.
    assign w_add_a = {1'b0, r_acc[PW-1:N]};
    assign w_add_b = r_acc[0] ? {1'b0, r_mcand} : '0;

    rca_adder #(
        .n (N + 1)
    ) u_adder (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    // Add-then-shift-right; the adder carry lands in the top accumulator bit.
    assign w_acc_step = {w_sum, r_acc[N-1:1]};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_product_nxt = r_product;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_mcand_nxt = bus.a;
                    w_acc_nxt   = {{N{1'b0}}, bus.b};
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CALC;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                w_acc_nxt = w_acc_step;
                w_cnt_nxt = CW'(r_cnt + CW'(1));
                if (r_cnt == CW'(N - 1)) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_product_nxt = w_acc_step;
                end else begin
                    w_busy_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed bench for seq_shift_add_mul: transaction-level model for N=8 checked
// every cycle, plus hand-computed expectations for N=8 and N=32.
module tb_seq_shift_add_mul;
    logic clk = 1'b0;
    logic rst8;
    logic rst32;

    always #5 clk = ~clk;

    seq_shift_add_mul_if #(.N(8))  if8();
    seq_shift_add_mul_if #(.N(32)) if32();

    seq_shift_add_mul #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8.slave)
    );

    seq_shift_add_mul #(.N(32)) dut32 (
        .clk (clk),
        .rst (rst32),
        .bus (if32.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted request produces a*b after N cycles.
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_pend = '0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        if (rst8) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
            m_pend = '0;
        end else begin
            bit take;
            take   = if8.start && !m_busy;
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_prod = m_pend;
                end
            end
            if (take) begin
                m_pend = 16'(if8.a) * 16'(if8.b);
                m_left = 8;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy8",    64'(if8.busy),    64'(m_busy));
            check("cyc_done8",    64'(if8.done),    64'(m_done));
            check("cyc_product8", 64'(if8.product), 64'(m_prod));
        end
    end

    // One N=8 operation; cycle k counts from the start cycle (k=0).
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output int nbusy, output int done_at);
        int k;
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b;
        @(negedge clk);
        if8.start = 1'b0; if8.a = ~a; if8.b = ~b;
        nbusy = 0; done_at = -1; k = 1;
        while (k <= 40 && done_at < 0) begin
            if (if8.busy) nbusy++;
            if (if8.done) done_at = k;
            if (done_at < 0) begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int da;
        int k;
        int ndone;
        int first;

        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if32.start = 1'b0; if32.a = '0; if32.b = '0;
        rst8 = 1'b1; rst32 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy8",     64'(if8.busy),     64'd0);
        check("rst_done8",     64'(if8.done),     64'd0);
        check("rst_product8",  64'(if8.product),  64'd0);
        check("rst_product32", 64'(if32.product), 64'd0);
        rst8 = 1'b0; rst32 = 1'b0;
        cmp_en = 1'b1;

        // 3 * 5, then product holds through idle cycles.
        run8(8'd3, 8'd5, nb, da);
        check("t1_busy_cycles", 64'(nb), 64'd8);
        check("t1_done_cycle",  64'(da), 64'd9);
        check("t1_product",     64'(if8.product), 64'h000F);
        check("t1_model",       64'(m_prod),      64'h000F);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t1_hold", 64'(if8.product), 64'h000F);
        end

        // Carry out on every iteration.
        run8(8'd255, 8'd255, nb, da);
        check("t2_done_cycle", 64'(da), 64'd9);
        check("t2_product",    64'(if8.product), 64'hFE01);
        check("t2_model",      64'(m_prod),      64'hFE01);

        // Zero operands still take the full latency.
        run8(8'd0, 8'd200, nb, da);
        check("t3a_busy_cycles", 64'(nb), 64'd8);
        check("t3a_product",     64'(if8.product), 64'd0);
        run8(8'd200, 8'd0, nb, da);
        check("t3b_busy_cycles", 64'(nb), 64'd8);
        check("t3b_done_cycle",  64'(da), 64'd9);
        check("t3b_product",     64'(if8.product), 64'd0);

        // Start during CALC is ignored.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd12; if8.b = 8'd11;
        @(negedge clk); if8.start = 1'b0; if8.a = 8'd1; if8.b = 8'd1;
        @(negedge clk);
        @(negedge clk); if8.start = 1'b1; if8.a = 8'd50; if8.b = 8'd60;
        @(negedge clk); if8.start = 1'b0;
        ndone = 0; first = -1;
        for (k = 4; k <= 30; k++) begin
            if (if8.done) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    check("t4_product", 64'(if8.product), 64'd132);
                end
            end
            @(negedge clk);
        end
        check("t4_done_count", 64'(ndone), 64'd1);
        check("t4_done_cycle", 64'(first), 64'd9);
        check("t4_hold",       64'(if8.product), 64'd132);

        // Start held high: back-to-back results every 9 cycles.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'd7; if8.b = 8'd9;
        ndone = 0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (if8.done) begin
                ndone++;
                check("t5_done_cycle", 64'(k), 64'(9 * ndone));
                check("t5_product",    64'(if8.product), 64'd63);
            end
        end
        check("t5_done_count", 64'(ndone), 64'd4);
        if8.start = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the middle of CALC.
        if8.start = 1'b1; if8.a = 8'd100; if8.b = 8'd100;
        @(negedge clk); if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk); rst8 = 1'b0;
        check("t6_busy",    64'(if8.busy),    64'd0);
        check("t6_product", 64'(if8.product), 64'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (if8.done) ndone++;
        end
        check("t6_no_done", 64'(ndone), 64'd0);
        run8(8'd2, 8'd3, nb, da);
        check("t6_done_cycle", 64'(da), 64'd9);
        check("t6_product2",   64'(if8.product), 64'd6);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst8 = 1'b1; if8.start = 1'b1; if8.a = 8'd9; if8.b = 8'd9;
        @(negedge clk);
        rst8 = 1'b0; if8.start = 1'b0;
        check("t7_busy",    64'(if8.busy),    64'd0);
        check("t7_product", 64'(if8.product), 64'd0);
        repeat (3) @(negedge clk);

        // N=32 all-ones.
        if32.start = 1'b1; if32.a = 32'hFFFF_FFFF; if32.b = 32'hFFFF_FFFF;
        @(negedge clk);
        if32.start = 1'b0; if32.a = '0; if32.b = '0;
        nb = 0; da = -1; k = 1;
        while (k <= 60 && da < 0) begin
            if (if32.busy) nb++;
            if (if32.done) da = k;
            if (da < 0) begin
                @(negedge clk);
                k++;
            end
        end
        check("t8_busy_cycles", 64'(nb), 64'd32);
        check("t8_done_cycle",  64'(da), 64'd33);
        check("t8_product",     if32.product, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        check("t8_done_pulse",  64'(if32.done), 64'd0);
        check("t8_hold",        if32.product, 64'hFFFF_FFFE_0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_shift_add_mul.md
Name: seq_shift_add_mul

Overview:
- Multi-cycle unsigned N x N -> 2N multiplier controller.
- Sequences a single shared ripple-carry adder, one partial product per cycle, instead of a combinational array multiplier.
- Sits beside the ALU in the execute stage; serves MUL/MULHU-class ops through a start/busy/done handshake.
- The pipeline stalls on busy.

Parameters:
- N, 32, operand width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  N  multiplicand; captured on the accepted start edge.
- b  input  N  multiplier; captured on the accepted start edge.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2N  unsigned result; held until the next accepted start.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous, active-high (rst) and overrides all other inputs.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Datapath registers:
  - mcand[N-1:0].
  - acc[2N-1:0]; the upper half is the running sum, the lower half holds the remaining multiplier bits.
  - cnt, sized ceil(log2(N+1)) bits.
- Adder: the team ripple-carry adder instantiated once with n=N+1, cin=0.
  - Operand A = {1'b0, acc[2N-1:N]}.
  - Operand B = {1'b0, mcand} when acc[0]=1, else 0.
  - Sum bit N is the carry-out; no other adder or multiplier may be used.
- FSM states:
  - IDLE: busy=0. start=1 -> mcand<=a; acc<={N'b0, b}; cnt<=0; go CALC.
  - CALC: busy=1. Each cycle acc<={sum[N:0], acc[N-1:1]} (add-then-shift-right), cnt<=cnt+1. When cnt==N-1 on this edge -> go DONE.
  - DONE: busy=0, done=1 for exactly this cycle. product is loaded from acc on the edge entering DONE and is stable during DONE. start=1 in DONE is accepted exactly as in IDLE (back-to-back); otherwise go IDLE.
- Latency:
  - Accepted start edge = E0.
  - CALC spans exactly N cycles: iterations on edges E1..EN.
  - done is high in the cycle following EN, which is N+1 cycles after the start cycle.
  - Throughput: one result per N+1 cycles.
- No early termination: b=0 or a=0 still takes N cycles.
- start while busy=1 is ignored; no queuing, no error flag.
- a/b may change freely after the accepted edge without affecting the result.
- product is unchanged from DONE until the edge that enters DONE again. It is not cleared by a new start.
- Width rules:
  - Result is the exact 2N-bit unsigned product; no overflow possible.
  - The carry from each add is preserved via sum bit N shifting into acc[2N-1].
- Reset mid-operation (CALC or DONE): returns to IDLE next edge; no done pulse; product=0.
- rst and start high together: reset wins; start is not accepted.
- Signed variants are handled outside this block: operand negation and sign fix-up by the caller.

Test Plan:
- N=8, a=3, b=5, start pulse 1 cycle -> busy high 8 cycles; done pulse in cycle 9 after start; product=15 (0x000F); product stays 15 for 20 idle cycles.
- N=8, a=255, b=255 -> product=65025 (0xFE01); exercises carry-out every iteration.
- N=8, a=0, b=200, then a=200, b=0 -> product=0 both times; each still takes exactly 8 busy cycles.
- N=8, a=12, b=11 start; change a, b and pulse start at CALC cycle 3 -> ignored; product=132; only one done pulse.
- N=8, start held high continuously with a=7, b=9 -> done every 9 cycles, product=63 each time, no idle gap between DONE and the next CALC.
- N=8, a=100, b=100 start; rst high at CALC cycle 4 for 1 cycle -> busy=0, done never pulses, product=0; fresh start a=2, b=3 -> product=6.
- N=32, a=0xFFFFFFFF, b=0xFFFFFFFF -> done after 33 cycles; product=0xFFFFFFFE00000001.
